// File: rtl/lsu_pkg.sv
// Shared encodings and decode helpers for the load/store unit controller.
package lsu_pkg;

    localparam logic [2:0] CTR_B  = 3'b000;
    localparam logic [2:0] CTR_H  = 3'b001;
    localparam logic [2:0] CTR_W  = 3'b010;
    localparam logic [2:0] CTR_BU = 3'b100;
    localparam logic [2:0] CTR_HU = 3'b101;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} lsu_state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

    function automatic logic ctr_illegal(input logic [2:0] ctr);
        return !(ctr inside {CTR_B, CTR_H, CTR_W, CTR_BU, CTR_HU});
    endfunction

    function automatic lsu_size_e ctr_size(input logic [2:0] ctr);
        if (ctr[1:0] == 2'b00) return SZ_B;
        if (ctr[1:0] == 2'b01) return SZ_H;
        return SZ_W;
    endfunction

    function automatic logic ctr_signed(input logic [2:0] ctr);
        return !ctr[2];
    endfunction

    function automatic logic is_misaligned(input logic [2:0] ctr, input logic [1:0] off);
        case (ctr_size(ctr))
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Word-wide memory request/response bus between the LSU (master) and memory (slave).
interface lsu_mem_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_wstrb;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wstrb, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wstrb, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and shift/extend for loads (purely combinational).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  ctr_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rd_o
);
    logic [31:0] shifted;
    logic        sext;

    assign shifted = rdata_i >> {off_i, 3'b000};
    assign sext    = ctr_signed(ctr_i);

    always_comb begin
        wstrb_o = 4'b1111;
        wdata_o = wd_i;
        rd_o    = shifted;
        case (ctr_size(ctr_i))
            SZ_B: begin
                wstrb_o = 4'b0001 << off_i;
                wdata_o = {4{wd_i[7:0]}};
                rd_o    = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                wstrb_o = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wd_i[15:0]}};
                rd_o    = {{16{sext & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller: accepts one op, issues one memory request, returns one result.
//
// state   | meaning
// IDLE    | ready for a new op
// REQ     | memory request presented, waiting for req_ready
// WAIT    | request accepted, waiting for response
// DONE    | one-cycle result pulse (out_valid)
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          in_we_i,
    input  logic [2:0]    in_ctr_i,
    input  logic [AW-1:0] in_addr_i,
    input  logic [DW-1:0] in_wd_i,
    output logic          out_valid_o,
    output logic [DW-1:0] out_rd_o,
    output logic          out_err_o,
    lsu_mem_if.master     mem
);
    lsu_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    ctr_q, ctr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wd_q, wd_d;
    logic [DW-1:0] rd_q, rd_d;
    logic          err_q, err_d;

    logic [3:0]    al_wstrb;
    logic [DW-1:0] al_wdata;
    logic [DW-1:0] al_rd;

    lsu_align u_align (
        .ctr_i   (ctr_q),
        .off_i   (addr_q[1:0]),
        .wd_i    (wd_q),
        .rdata_i (mem.rsp_rdata),
        .wstrb_o (al_wstrb),
        .wdata_o (al_wdata),
        .rd_o    (al_rd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            ctr_q   <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            ctr_q   <= ctr_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        ctr_d   = ctr_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    we_d   = in_we_i;
                    ctr_d  = in_ctr_i;
                    addr_d = in_addr_i;
                    wd_d   = in_wd_i;
                    rd_d   = '0;
                    // Bad ops skip memory entirely and report straight from DONE.
                    if (ctr_illegal(in_ctr_i) || is_misaligned(in_ctr_i, in_addr_i[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem.req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem.rsp_valid) begin
                    rd_d    = we_q ? '0 : al_rd;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready_o    = (state_q == ST_IDLE);
    assign out_valid_o   = (state_q == ST_DONE);
    assign out_rd_o      = rd_q;
    assign out_err_o     = err_q;

    assign mem.req_valid = (state_q == ST_REQ);
    assign mem.req_we    = we_q;
    assign mem.req_addr  = {addr_q[AW-1:2], 2'b00};
    assign mem.req_wstrb = we_q ? al_wstrb : 4'b0000;
    assign mem.req_wdata = al_wdata;
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width; only 32 is supported.
REQ-003 Port clk, in, 1: single clock, rising edge.
REQ-004 Port rst_n, in, 1: reset, asynchronous, active-low.
REQ-005 Pipeline-side ports: in_valid in 1, in_ready out 1, in_we in 1, in_ctr in 3, in_addr in AW, in_wd in DW.
- in_ctr encoding: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
REQ-006 Result ports: out_valid out 1 (one-cycle pulse), out_rd out DW, out_err out 1.
REQ-007 Memory request ports: mem_req_valid out 1, mem_req_ready in 1, mem_req_we out 1, mem_req_addr out AW (word-aligned), mem_req_wstrb out 4, mem_req_wdata out DW.
REQ-008 Memory response ports: mem_rsp_valid in 1, mem_rsp_rdata in DW; a response is required for both reads and writes.

Function
REQ-009 The FSM SHALL have states IDLE, REQ, WAIT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-010 IDLE with in_valid=1 SHALL latch we/ctr/addr/wd and go to REQ; an illegal or misaligned op SHALL instead go to DONE with err=1.
REQ-011 An op is illegal if ctr is 011, 110 or 111.
REQ-012 An op is misaligned if it is a half access with addr[0]=1, or a word access with addr[1:0]!=0.
REQ-013 In REQ, mem_req_valid SHALL be 1 and all mem_req_* fields SHALL be stable until mem_req_ready=1, then the FSM SHALL go to WAIT.
REQ-014 mem_req_addr SHALL equal {addr[AW-1:2],2'b00}.
REQ-015 Write strobes SHALL be: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100 (addr[1]=1); word 1111.
REQ-016 Write data SHALL be replicated into lanes: byte as {4{wd[7:0]}}, half as {2{wd[15:0]}}, word as wd.
REQ-017 mem_rsp_valid SHALL be sampled only in WAIT and ignored in all other states; the responder never responds in the cycle it accepts a request.
REQ-018 On mem_rsp_valid in WAIT, the block SHALL register the extracted load data and go to DONE.
REQ-019 Load extraction SHALL right-shift rdata by 8*addr[1:0], then sign-extend (000, 001) or zero-extend (100, 101).
REQ-020 DONE SHALL last exactly one cycle with out_valid=1, then return to IDLE; out_valid has no backpressure.
REQ-021 For stores and errored ops, out_rd SHALL be 0; out_err SHALL be 1 only for illegal or misaligned ops.
REQ-022 Minimum latency SHALL be: accept at cycle 0, mem_req_valid at cycle 1, response at cycle 2 or later, out_valid one cycle after the response.
REQ-023 Error latency SHALL be out_valid at cycle 1, with no memory request issued.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, with out_valid=0, out_err=0, out_rd=0 and mem_req_valid=0.
REQ-025 Reset mid-transaction SHALL abandon the op without a result; a stale response arriving after reset is ignored because it arrives in IDLE.
REQ-026 All latched request fields SHALL reset to 0.

Structure
REQ-027 A shared package lsu_pkg SHALL hold:
- the ctr encoding constants;
- the state enum;
- the size/extension decode helpers.
REQ-028 Lane steering and extension (REQ-015, REQ-016, REQ-019) SHALL be a combinational sub-module lsu_align, instantiated once.

Verification
REQ-029 Scenario "lb": addr=0x80000003, ctr=000, rdata=0x80FF1234 -> out_rd=0xFFFFFF80, err=0.
REQ-030 Scenario "sh": addr=0x80000006, ctr=001, wd=0x0000BEEF -> mem_req_addr=0x80000004, wstrb=1100, wdata=0xBEEFBEEF, out_rd=0.
REQ-031 Scenario "misaligned lw": addr=0x80000002, ctr=010 -> no mem_req_valid, out_valid at cycle 1 with out_err=1.
REQ-032 Scenario "backpressure": mem_req_ready held 0 for 3 cycles -> request fields stable throughout, in_ready=0, in_valid ignored.
REQ-033 Scenario "reset in WAIT": rst_n pulsed low, then a late mem_rsp_valid -> no out_valid, state IDLE, in_ready=1.
REQ-034 Scenario "lhu": addr=0x80000002, rdata=0xA5A5_0000 -> out_rd=0x0000A5A5.
